// File: rtl/elevator_motion_sched_if.sv
// Elevator scheduler status bundle: call buttons in, car position/motion/door status out.
// Combinational wires only; no latency and no backpressure.
// Status outputs are free-running and must be sampled by the consumer every cycle.
interface elevator_motion_sched_if #(
    parameter int N_FLOORS = 4
) ();
    localparam int FW = (N_FLOORS > 1) ? $clog2(N_FLOORS) : 1;

    logic [N_FLOORS-1:0] req;
    logic [FW-1:0]       cur_floor;
    logic [N_FLOORS-1:0] pending;
    logic                moving_up;
    logic                moving_down;
    logic                door_open;
    logic                tick;

    modport master (
        output req,
        input  cur_floor, pending, moving_up, moving_down, door_open, tick
    );

    modport slave (
        input  req,
        output cur_floor, pending, moving_up, moving_down, door_open, tick
    );
endinterface

// File: rtl/elevator_motion_sched.sv
// SCAN floor scheduler with prescaled travel/door-dwell timing and registered status.
// Latency: req visible in pending 1 cycle later; IDLE leaves for MOVE/DOOR on the req edge.
// Backpressure: none; calls are latched until served, repeated presses merge.
module elevator_motion_sched #(
    parameter int N_FLOORS    = 4,
    parameter int TICK_DIV    = 50_000_000,
    parameter int FLOOR_TICKS = 2,
    parameter int DOOR_TICKS  = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    elevator_motion_sched_if.slave bus
);
    localparam int FW   = (N_FLOORS > 1) ? $clog2(N_FLOORS) : 1;
    localparam int PW   = $clog2(TICK_DIV);
    localparam int MAXT = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
    localparam int HW   = $clog2(MAXT + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [HW-1:0] FLOOR_LAST = HW'(FLOOR_TICKS - 1);
    localparam logic [HW-1:0] DOOR_LAST  = HW'(DOOR_TICKS - 1);
    localparam logic [FW-1:0] TOP_FLOOR  = FW'(N_FLOORS - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_MOVE, ST_DOOR} state_t;
    typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

    state_t              state_q, state_d;
    dir_t                dir_q, dir_d;
    logic [FW-1:0]       cur_floor_q, cur_floor_d;
    logic [N_FLOORS-1:0] pending_q, pending_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic [HW-1:0]       phase_q, phase_d;

    logic [N_FLOORS-1:0] pend_or;
    logic [N_FLOORS-1:0] serve;
    logic                call_above, call_below;
    logic                go_up, go_down;
    logic                tick_w, floor_done, door_done, at_end;
    logic [FW-1:0]       next_floor;

    assign pend_or = pending_q | bus.req;

    always_comb begin
        call_above = 1'b0;
        call_below = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (pend_or[i] && (i > int'(cur_floor_q))) call_above = 1'b1;
            if (pend_or[i] && (i < int'(cur_floor_q))) call_below = 1'b1;
        end
    end

    // SCAN: keep the current heading while anything remains ahead of it.
    assign go_up   = (dir_q == DIR_UP) ? call_above : (call_above && !call_below);
    assign go_down = (dir_q == DIR_UP) ? (call_below && !call_above) : call_below;

    assign next_floor = (dir_q == DIR_UP) ? cur_floor_q + FW'(1) : cur_floor_q - FW'(1);
    assign at_end     = (dir_q == DIR_UP) ? (cur_floor_q == TOP_FLOOR) : (cur_floor_q == '0);

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        cur_floor_d = cur_floor_q;
        serve       = '0;
        presc_d     = '0;
        phase_d     = '0;
        tick_w      = (state_q != ST_IDLE) && (presc_q == PRESC_LAST);
        if (state_q != ST_IDLE) begin
            presc_d = tick_w ? '0 : presc_q + PW'(1);
            phase_d = tick_w ? phase_q + HW'(1) : phase_q;
        end
        floor_done = tick_w && (phase_q == FLOOR_LAST);
        door_done  = tick_w && (phase_q == DOOR_LAST);

        case (state_q)
            ST_IDLE: begin
                if (pend_or[cur_floor_q]) begin
                    state_d            = ST_DOOR;
                    serve[cur_floor_q] = 1'b1;
                end else if (go_up) begin
                    state_d = ST_MOVE;
                    dir_d   = DIR_UP;
                end else if (go_down) begin
                    state_d = ST_MOVE;
                    dir_d   = DIR_DOWN;
                end
            end
            ST_MOVE: begin
                if (floor_done) begin
                    phase_d = '0;
                    // Unreachable while a target lies ahead; stops the car rather than wrapping.
                    if (at_end) begin
                        state_d = ST_IDLE;
                    end else begin
                        cur_floor_d = next_floor;
                        if (pend_or[next_floor]) begin
                            state_d           = ST_DOOR;
                            serve[next_floor] = 1'b1;
                        end
                    end
                end
            end
            ST_DOOR: begin
                // A press at the open floor extends the dwell instead of queueing a call.
                serve[cur_floor_q] = 1'b1;
                if (bus.req[cur_floor_q]) begin
                    presc_d = '0;
                    phase_d = '0;
                end else if (door_done) begin
                    phase_d = '0;
                    if (go_up) begin
                        state_d = ST_MOVE;
                        dir_d   = DIR_UP;
                    end else if (go_down) begin
                        state_d = ST_MOVE;
                        dir_d   = DIR_DOWN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        pending_d = pend_or & ~serve;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            dir_q       <= DIR_UP;
            cur_floor_q <= '0;
            pending_q   <= '0;
            presc_q     <= '0;
            phase_q     <= '0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            cur_floor_q <= cur_floor_d;
            pending_q   <= pending_d;
            presc_q     <= presc_d;
            phase_q     <= phase_d;
        end
    end

    assign bus.cur_floor   = cur_floor_q;
    assign bus.pending     = pending_q;
    assign bus.moving_up   = (state_q == ST_MOVE) && (dir_q == DIR_UP);
    assign bus.moving_down = (state_q == ST_MOVE) && (dir_q == DIR_DOWN);
    assign bus.door_open   = (state_q == ST_DOOR);
    assign bus.tick        = tick_w;
endmodule
